// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the IN/OUT unit of the single-cycle
// MIPS datapath. Holds the handshake FSM encoding and the 7-segment lookup
// used by the optional display decoder (DISPLAY_7SEG_EN).
package io_pkg;

    // Handshake FSM states; encoding is fixed so it can be probed on a bench/ILA.
    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_SOLTO  = 3'd1,
        ESPERA_APERTO = 3'd2,
        ESPERA_LIBERA = 3'd3,
        CONCLUI       = 3'd4
    } estado_t;

    // Active-high segment patterns {g,f,e,d,c,b,a}, entry [n] is hex digit n.
    localparam logic [15:0][6:0] HEX7SEG_TAB = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Board segments are active-low, so the table is inverted on lookup.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        return ~HEX7SEG_TAB[nib];
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: two-flop synchronizer, stability counter and filtered level
// for a bouncing asynchronous push button. Also produces a one-cycle pulse
// that is high in the first cycle the filtered level reads 1.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_async,
    output logic filtrado,
    output logic subida
);

    localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic          sub_q;
    logic          sub_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the raw button into the clock domain before anything looks at it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_async;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; flip the filtered level once
    // the new level has been seen long enough. Any agreement restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        sub_d  = 1'b0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CICLOS - 1)) begin
                filt_d = ~filt_q;
                sub_d  = ~filt_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
            sub_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            sub_q  <= sub_d;
        end
    end

    assign filtrado = filt_q;
    assign subida   = sub_q;

endmodule

// File: rtl/unidade_entrada_saida.sv
// unidade_entrada_saida: IN/OUT responder for the single-cycle MIPS datapath.
// IN stalls the CPU until the user presses and releases the confirm button;
// the switch value is captured on the press and handed to the register file
// (in_pronto) on the release. OUT latches the RS operand into a persistent
// display register. Define DISPLAY_7SEG_EN to add the registered hex_out
// 7-segment decode of display_reg[15:0].
module unidade_entrada_saida
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  IOE,
    input  logic                  IOsel,
    input  logic                  stall_req,
    input  logic [DATA_WIDTH-1:0] dado_rs,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  btn_confirma,
    output logic [DATA_WIDTH-1:0] dado_entrada,
    output logic                  stall_cpu,
    output logic                  in_pronto,
    output logic [DATA_WIDTH-1:0] display_reg,
    output logic                  out_pulso
`ifdef DISPLAY_7SEG_EN
    ,
    output logic [4*7-1:0]        hex_out
`endif
);

    estado_t               estado_q;
    estado_t               estado_d;
    logic [SW_WIDTH-1:0]   sw_sync1_q;
    logic [SW_WIDTH-1:0]   sw_sync2_q;
    logic [DATA_WIDTH-1:0] dado_q;
    logic [DATA_WIDTH-1:0] dado_d;
    logic [DATA_WIDTH-1:0] display_q;
    logic [DATA_WIDTH-1:0] display_d;
    logic                  out_pulso_q;
    logic                  out_pulso_d;
    logic                  captura;
    logic                  in_req;
    logic                  out_req;
    logic                  btn_filt;
    logic                  btn_sub;

    assign in_req  = IOE & IOsel & stall_req;
    assign out_req = IOE & ~IOsel;

    debounce_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .btn_async(btn_confirma),
        .filtrado (btn_filt),
        .subida   (btn_sub)
    );

    // Switches are asynchronous; sample them through two flops before capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= switches;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Handshake next-state: a button already held at IN decode must be let go
    // first, so a press left over from the previous IN cannot confirm this one.
    always_comb begin
        estado_d = estado_q;
        captura  = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (in_req) begin
                    estado_d = btn_filt ? ESPERA_SOLTO : ESPERA_APERTO;
                end
            end
            ESPERA_SOLTO: begin
                if (!btn_filt) begin
                    estado_d = ESPERA_APERTO;
                end
            end
            ESPERA_APERTO: begin
                if (btn_sub) begin
                    captura  = 1'b1;
                    estado_d = ESPERA_LIBERA;
                end
            end
            ESPERA_LIBERA: begin
                if (!btn_filt) begin
                    estado_d = CONCLUI;
                end
            end
            CONCLUI: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Data capture and OUT latch; OUT is only honoured while no IN is pending.
    always_comb begin
        dado_d      = dado_q;
        display_d   = display_q;
        out_pulso_d = 1'b0;
        if (captura) begin
            dado_d = DATA_WIDTH'(sw_sync2_q);
        end
        if (out_req && (estado_q == OCIOSO)) begin
            display_d   = dado_rs;
            out_pulso_d = 1'b1;
        end
    end

    // Data and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dado_q      <= '0;
            display_q   <= '0;
            out_pulso_q <= 1'b0;
        end else begin
            dado_q      <= dado_d;
            display_q   <= display_d;
            out_pulso_q <= out_pulso_d;
        end
    end

    // The stall must rise in the very cycle IN is decoded (no PC advance), and
    // a reset drops it immediately rather than one cycle later.
    always_comb begin
        stall_cpu = 1'b0;
        in_pronto = 1'b0;
        if (!reset) begin
            unique case (estado_q)
                OCIOSO:        stall_cpu = in_req;
                ESPERA_SOLTO,
                ESPERA_APERTO,
                ESPERA_LIBERA: stall_cpu = 1'b1;
                CONCLUI:       in_pronto = 1'b1;
                default:       stall_cpu = 1'b0;
            endcase
        end
    end

    assign dado_entrada = dado_q;
    assign display_reg  = display_q;
    assign out_pulso    = out_pulso_q;

`ifdef DISPLAY_7SEG_EN
    logic [4*7-1:0] hex_q;
    logic [4*7-1:0] hex_d;

    // Decode the low half-word of the display register, four hex digits.
    always_comb begin
        hex_d = {hex7seg(display_q[15:12]), hex7seg(display_q[11:8]),
                 hex7seg(display_q[7:4]),   hex7seg(display_q[3:0])};
    end

    // Segment register, one cycle behind display_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_q <= {4{hex7seg(4'h0)}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex_out = hex_q;
`endif

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// Bench for unidade_entrada_saida with DEBOUNCE_CICLOS=4: table-driven IN and
// OUT transactions plus hand-written bounce, held-button and reset sequences.
module tb_unidade_entrada_saida;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          IOE;
    logic          IOsel;
    logic          stall_req;
    logic [DW-1:0] dado_rs;
    logic [SW-1:0] switches;
    logic          btn_confirma;
    logic [DW-1:0] dado_entrada;
    logic          stall_cpu;
    logic          in_pronto;
    logic [DW-1:0] display_reg;
    logic          out_pulso;
`ifdef DISPLAY_7SEG_EN
    logic [27:0]   hex_out;
    localparam logic [27:0] HEX_BEEF = {7'h03, 7'h06, 7'h06, 7'h0E};
`endif

    unidade_entrada_saida #(
        .DATA_WIDTH(DW), .SW_WIDTH(SW), .DEBOUNCE_CICLOS(DB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .IOE         (IOE),
        .IOsel       (IOsel),
        .stall_req   (stall_req),
        .dado_rs     (dado_rs),
        .switches    (switches),
        .btn_confirma(btn_confirma),
        .dado_entrada(dado_entrada),
        .stall_cpu   (stall_cpu),
        .in_pronto   (in_pronto),
        .display_reg (display_reg),
        .out_pulso   (out_pulso)
`ifdef DISPLAY_7SEG_EN
        ,
        .hex_out     (hex_out)
`endif
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [SW-1:0] sw;
        logic [DW-1:0] exp;
    } in_vec_t;

    typedef struct {
        logic [DW-1:0] rs;
        logic [DW-1:0] exp;
    } out_vec_t;

    in_vec_t  in_tab[4];
    out_vec_t out_tab[4];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Wait for the in_pronto pulse after release, bounded; drops IN once seen.
    task automatic wait_pronto(output int pulses, output logic st, output logic [DW-1:0] dv);
        bit seen;
        seen   = 1'b0;
        pulses = 0;
        st     = 1'b1;
        dv     = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (in_pronto) begin
                pulses++;
                if (!seen) begin
                    st = stall_cpu;
                    dv = dado_entrada;
                end
                seen = 1'b1;
            end
            cyc();
            if (seen) begin
                IOE = 1'b0; IOsel = 1'b0; stall_req = 1'b0;
            end
        end
    endtask

    // Watch n cycles; report whether stall ever dropped and in_pronto count.
    task automatic watch(input int n, output bit stall_low, output int pulses);
        stall_low = 1'b0;
        pulses    = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (!stall_cpu) stall_low = 1'b1;
            if (in_pronto) pulses++;
            cyc();
        end
    endtask

    task automatic start_in();
        IOE = 1'b1; IOsel = 1'b1; stall_req = 1'b1;
    endtask

    task automatic run_in(input logic [SW-1:0] sw, input logic [DW-1:0] exp, input string nm);
        bit            sl;
        int            p;
        logic          st;
        logic [DW-1:0] dv;
        switches = sw;
        cyc(); cyc();
        start_in();
        @(negedge clock);
        chk({nm, "_stall_decode"}, DW'(stall_cpu), 32'd1);
        cyc();
        btn_confirma = 1'b1;
        watch(10, sl, p);
        chk({nm, "_stall_hold"}, DW'(sl), 32'd0);
        chk({nm, "_early_pronto"}, DW'(p), 32'd0);
        chk({nm, "_capture"}, dado_entrada, exp);
        switches = ~sw;
        btn_confirma = 1'b0;
        wait_pronto(p, st, dv);
        chk({nm, "_pronto_count"}, DW'(p), 32'd1);
        chk({nm, "_pronto_stall"}, DW'(st), 32'd0);
        chk({nm, "_pronto_data"}, dv, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            sl;
        int            p;
        logic          st;
        logic [DW-1:0] dv;

        in_tab[0] = '{16'hA5C3, 32'h0000A5C3};
        in_tab[1] = '{16'hFFFF, 32'h0000FFFF};
        in_tab[2] = '{16'h0000, 32'h00000000};
        in_tab[3] = '{16'h1234, 32'h00001234};
        out_tab[0] = '{32'hDEADBEEF, 32'hDEADBEEF};
        out_tab[1] = '{32'h12345678, 32'h12345678};
        out_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        out_tab[3] = '{32'h00000001, 32'h00000001};

        // Reset with the button held.
        reset = 1'b1; btn_confirma = 1'b1; IOE = 1'b0; IOsel = 1'b0; stall_req = 1'b0;
        dado_rs = '0; switches = '0;
        cyc(); cyc(); cyc();
        @(negedge clock);
        chk("rst_dado", dado_entrada, 32'd0);
        chk("rst_display", display_reg, 32'd0);
        chk("rst_pronto", DW'(in_pronto), 32'd0);
        chk("rst_outp", DW'(out_pulso), 32'd0);
        chk("rst_stall", DW'(stall_cpu), 32'd0);
        cyc();
        reset = 1'b0; btn_confirma = 1'b0;
        cyc();
        @(negedge clock);
        chk("post_rst_stall", DW'(stall_cpu), 32'd0);
        chk("post_rst_pronto", DW'(in_pronto), 32'd0);
        cyc(); cyc();

        // OUT transactions.
        for (int i = 0; i < 4; i++) begin
            IOE = 1'b1; IOsel = 1'b0; stall_req = 1'b0; dado_rs = out_tab[i].rs;
            @(negedge clock);
            chk($sformatf("out%0d_stall", i), DW'(stall_cpu), 32'd0);
            cyc();
            IOE = 1'b0; dado_rs = 32'h0BAD0BAD;
            @(negedge clock);
            chk($sformatf("out%0d_disp", i), display_reg, out_tab[i].exp);
            chk($sformatf("out%0d_pulse", i), DW'(out_pulso), 32'd1);
            chk($sformatf("out%0d_stall2", i), DW'(stall_cpu), 32'd0);
            cyc();
            @(negedge clock);
            chk($sformatf("out%0d_pulse_end", i), DW'(out_pulso), 32'd0);
            chk($sformatf("out%0d_hold", i), display_reg, out_tab[i].exp);
`ifdef DISPLAY_7SEG_EN
            if (out_tab[i].rs == 32'hDEADBEEF) chk("hex_beef", DW'(hex_out), DW'(HEX_BEEF));
`endif
            cyc();
        end

        // IN with stall_req low is a no-op.
        IOE = 1'b1; IOsel = 1'b1; stall_req = 1'b0;
        @(negedge clock);
        chk("noop_stall", DW'(stall_cpu), 32'd0);
        cyc();
        IOE = 1'b0; IOsel = 1'b0;
        watch(3, sl, p);
        chk("noop_stall_low", DW'(sl), 32'd1);
        chk("noop_pronto", DW'(p), 32'd0);
        chk("noop_disp", display_reg, 32'h00000001);

        // Clean IN transactions.
        for (int i = 0; i < 4; i++) begin
            run_in(in_tab[i].sw, in_tab[i].exp, $sformatf("in%0d", i));
            cyc(); cyc();
        end

        // Bouncing press: 1-0-1-0 one-cycle glitches, then held.
        switches = 16'h0F0F;
        cyc(); cyc();
        start_in();
        cyc();
        btn_confirma = 1'b1; cyc();
        btn_confirma = 1'b0; cyc();
        btn_confirma = 1'b1; cyc();
        btn_confirma = 1'b0; cyc();
        btn_confirma = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        @(negedge clock);
        chk("bounce_no_capture", dado_entrada, 32'h00001234);
        chk("bounce_stall", DW'(stall_cpu), 32'd1);
        cyc();
        watch(6, sl, p);
        chk("bounce_capture", dado_entrada, 32'h00000F0F);
        chk("bounce_stall_hold", DW'(sl), 32'd0);
        switches = 16'hBEEF;
        btn_confirma = 1'b0;
        wait_pronto(p, st, dv);
        chk("bounce_pronto_count", DW'(p), 32'd1);
        chk("bounce_pronto_data", dv, 32'h00000F0F);
        cyc();

        // IN issued while the filtered button is already high.
        btn_confirma = 1'b1;
        watch(10, sl, p);
        switches = 16'h1111;
        cyc(); cyc();
        start_in();
        @(negedge clock);
        chk("held_stall_decode", DW'(stall_cpu), 32'd1);
        cyc();
        switches = 16'h2222;
        btn_confirma = 1'b0;
        watch(12, sl, p);
        chk("held_stall_release", DW'(sl), 32'd0);
        chk("held_no_pronto", DW'(p), 32'd0);
        chk("held_no_capture", dado_entrada, 32'h00000F0F);
        switches = 16'h3333;
        cyc(); cyc();
        btn_confirma = 1'b1;
        watch(10, sl, p);
        chk("held_fresh_capture", dado_entrada, 32'h00003333);
        chk("held_stall_press", DW'(sl), 32'd0);
        switches = 16'h4444;
        btn_confirma = 1'b0;
        wait_pronto(p, st, dv);
        chk("held_pronto_count", DW'(p), 32'd1);
        chk("held_pronto_stall", DW'(st), 32'd0);
        chk("held_pronto_data", dv, 32'h00003333);
        cyc();

        // Reset while waiting for release.
        switches = 16'h5A5A;
        cyc(); cyc();
        start_in();
        cyc();
        btn_confirma = 1'b1;
        watch(10, sl, p);
        chk("rstw_capture", dado_entrada, 32'h00005A5A);
        reset = 1'b1;
        @(negedge clock);
        chk("rstw_stall_same_cycle", DW'(stall_cpu), 32'd0);
        chk("rstw_pronto_same_cycle", DW'(in_pronto), 32'd0);
        cyc();
        reset = 1'b0; IOE = 1'b0; IOsel = 1'b0; stall_req = 1'b0; btn_confirma = 1'b0;
        @(negedge clock);
        chk("rstw_dado", dado_entrada, 32'd0);
        chk("rstw_stall", DW'(stall_cpu), 32'd0);
        cyc();
        watch(20, sl, p);
        chk("rstw_no_pronto", DW'(p), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
